conv_layer_sequencer: RTL and testbench

Multi-layer scheduler for the conv2d accelerator. It reads per-layer descriptors from a descriptor BRAM and copies parameters and kernel words into the accelerator's control memory. It then arms the start bit, polls the done bit and advances to the next layer. It sits on the second port of the dual-port control BRAM, beside the accelerator top, and is driven by a host run/abort pair.

---
 rtl/conv_layer_sequencer.sv | 166 ++++++++++++++++
 tb/tb_conv_layer_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_layer_sequencer.sv
// Multi-layer scheduler for the conv2d accelerator: copies per-layer descriptors
// into the control BRAM, arms the start bit, polls done and advances layers.
module conv_layer_sequencer #(
    parameter int TIMEOUT_W = 20
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_run,
    input  logic        i_abort,
    input  logic [4:0]  i_num_layers,
    output logic [7:0]  o_desc_addr,
    input  logic [31:0] i_desc_data,
    output logic [3:0]  o_ctrl_addr,
    output logic        o_ctrl_we,
    output logic [31:0] o_ctrl_data,
    input  logic [31:0] i_ctrl_data,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [3:0]  o_cur_layer
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ARM, S_WAIT, S_CLEAR, S_NEXT, S_ABORT
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           layer_q, layer_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [4:0]           num_q, num_d;
    logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
    logic                 err_q, err_d;
    logic                 zero_done_q, zero_done_d;

    logic       abort_hit;
    logic       wait_done;
    logic       wait_timeout;
    logic       last_layer;
    logic [2:0] flags;
    logic       ctrl_rd_unused;

    assign abort_hit    = i_abort && (state_q != S_IDLE);
    assign flags        = i_desc_data[2:0];
    // The first WAIT cycle still carries the read issued before the start write.
    assign wait_done    = (wdog_q != '0) && i_ctrl_data[1];
    assign wait_timeout = &wdog_q;
    assign last_layer   = (({1'b0, layer_q} + 5'd1) == num_q);
    assign ctrl_rd_unused = ^{i_ctrl_data[31:2], i_ctrl_data[0]};

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= S_IDLE;
            layer_q     <= 4'd0;
            cnt_q       <= 4'd0;
            num_q       <= 5'd0;
            wdog_q      <= '0;
            err_q       <= 1'b0;
            zero_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            layer_q     <= layer_d;
            cnt_q       <= cnt_d;
            num_q       <= num_d;
            wdog_q      <= wdog_d;
            err_q       <= err_d;
            zero_done_q <= zero_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        layer_d     = layer_q;
        cnt_d       = cnt_q;
        num_d       = num_q;
        wdog_d      = wdog_q;
        err_d       = err_q;
        zero_done_d = 1'b0;
        if (abort_hit) begin
            state_d = S_ABORT;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_run) begin
                        err_d   = 1'b0;
                        layer_d = 4'd0;
                        cnt_d   = 4'd0;
                        num_d   = (i_num_layers > 5'd16) ? 5'd16 : i_num_layers;
                        if (i_num_layers == 5'd0) begin
                            zero_done_d = 1'b1;
                        end else begin
                            state_d = S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd11) begin
                        state_d = S_ARM;
                    end
                end
                S_ARM: begin
                    wdog_d  = '0;
                    state_d = (flags == 3'd0) ? S_NEXT : S_WAIT;
                end
                S_WAIT: begin
                    wdog_d = wdog_q + 1'b1;
                    if (wait_done) begin
                        state_d = S_CLEAR;
                    end else if (wait_timeout) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_CLEAR: state_d = S_NEXT;
                S_NEXT: begin
                    if (last_layer) begin
                        state_d = S_IDLE;
                    end else begin
                        layer_d = layer_q + 4'd1;
                        cnt_d   = 4'd0;
                        state_d = S_LOAD;
                    end
                end
                S_ABORT: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // An abort suppresses every write and done pulse of its own cycle.
    always_comb begin
        o_desc_addr = 8'd0;
        o_ctrl_addr = 4'd0;
        o_ctrl_we   = 1'b0;
        o_ctrl_data = 32'd0;
        o_done      = zero_done_q;
        case (state_q)
            S_LOAD: begin
                o_desc_addr = {layer_q, cnt_q};
                o_ctrl_addr = cnt_q + 4'd1;
                o_ctrl_we   = (cnt_q != 4'd0) && !abort_hit;
                o_ctrl_data = i_desc_data;
            end
            S_ARM: begin
                o_desc_addr = {layer_q, 4'd11};
                o_ctrl_we   = (flags != 3'd0) && !abort_hit;
                o_ctrl_data = {23'd0, layer_q, flags, 1'b0, 1'b1};
            end
            S_WAIT: begin
                if (!abort_hit && !wait_done && wait_timeout) begin
                    o_ctrl_we = 1'b1;
                    o_done    = 1'b1;
                end
            end
            S_CLEAR: o_ctrl_we = !abort_hit;
            S_NEXT:  o_done    = last_layer && !abort_hit;
            S_ABORT: o_ctrl_we = 1'b1;
            default: ;
        endcase
    end

    assign o_busy      = (state_q != S_IDLE);
    assign o_err       = err_q;
    assign o_cur_layer = layer_q;

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Directed-plus-random bench for conv_layer_sequencer with descriptor/control
// BRAM models, a datapath done model and a descriptor-level write-list model.
`timescale 1ns/1ps
module tb_conv_layer_sequencer;

    localparam int TW = 7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        abort = 1'b0;
    logic [4:0]  num_layers = 5'd0;
    logic [7:0]  desc_addr;
    logic [31:0] desc_rd = 32'd0;
    logic [3:0]  ctrl_addr;
    logic        ctrl_we;
    logic [31:0] ctrl_wdata;
    logic [31:0] ctrl_rd = 32'd0;
    logic        busy, done, err;
    logic [3:0]  cur_layer;

    logic [31:0] desc_mem [256];
    logic [31:0] ctrl_mem [16];
    int          cyc = 0;
    bit          dp_enable = 1'b0;
    int          dp_delay = 10;
    int          dp_cnt = 0;
    bit          dp_active = 1'b0;

    logic [35:0] got_q[$];
    logic [35:0] exp_q[$];
    int          got_cyc[$];
    logic [3:0]  lay_q[$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          idle_we = 0;
    bit          mon_en = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    conv_layer_sequencer #(.TIMEOUT_W(TW)) dut (
        .i_clk        (clk),
        .i_rst        (rst_n),
        .i_run        (run),
        .i_abort      (abort),
        .i_num_layers (num_layers),
        .o_desc_addr  (desc_addr),
        .i_desc_data  (desc_rd),
        .o_ctrl_addr  (ctrl_addr),
        .o_ctrl_we    (ctrl_we),
        .o_ctrl_data  (ctrl_wdata),
        .i_ctrl_data  (ctrl_rd),
        .o_busy       (busy),
        .o_done       (done),
        .o_err        (err),
        .o_cur_layer  (cur_layer)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // BRAM models plus a datapath that raises done a fixed delay after a start write.
    always @(posedge clk) begin
        desc_rd <= desc_mem[desc_addr];
        ctrl_rd <= ctrl_mem[ctrl_addr];
        if (ctrl_we) ctrl_mem[ctrl_addr] <= ctrl_wdata;
        if (ctrl_we && ctrl_addr == 4'd0 && ctrl_wdata[0]) begin
            dp_active <= dp_enable;
            dp_cnt    <= dp_delay;
        end else if (dp_active) begin
            if (dp_cnt == 0) begin
                ctrl_mem[0][1] <= 1'b1;
                dp_active      <= 1'b0;
            end else begin
                dp_cnt <= dp_cnt - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (ctrl_we) begin
                got_q.push_back({ctrl_addr, ctrl_wdata});
                got_cyc.push_back(cyc);
                if (ctrl_addr == 4'd2) lay_q.push_back(cur_layer);
                if (!busy) idle_we++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic check_output(input string tag, input logic [35:0] got, input logic [35:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_mon();
        got_q.delete();
        got_cyc.delete();
        lay_q.delete();
        done_cnt = 0;
        done_cyc = 0;
    endtask

    task automatic apply_stimulus(input logic [4:0] n, output int t);
        num_layers = n;
        run = 1'b1;
        t = cyc;
        tick();
        run = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max_cycles);
        int k = 0;
        while (busy && k < max_cycles) begin
            tick();
            k++;
        end
        if (busy) check_output({tag, "_hang"}, 36'(busy), 36'd0);
        tick();
        tick();
    endtask

    task automatic fill_layer(input int l, input logic [2:0] fl);
        for (int k = 0; k < 16; k++) desc_mem[l*16 + k] = $urandom;
        desc_mem[l*16 + 11] = {29'($urandom), fl};
    endtask

    // Expected control writes derived from the descriptor contents alone.
    task automatic build_expected(input int n);
        int eff = (n > 16) ? 16 : n;
        exp_q.delete();
        for (int l = 0; l < eff; l++) begin
            logic [2:0] fl;
            for (int k = 0; k < 11; k++) exp_q.push_back({4'(k + 2), desc_mem[l*16 + k]});
            fl = desc_mem[l*16 + 11][2:0];
            if (fl != 3'd0) begin
                exp_q.push_back({4'd0, 23'd0, 4'(l), fl, 2'b01});
                exp_q.push_back({4'd0, 32'd0});
            end
        end
    endtask

    task automatic compare_writes(input string tag);
        check_output({tag, "_nwrites"}, 36'(got_q.size()), 36'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check_output($sformatf("%s_wr%0d", tag, i), got_q[i], exp_q[i]);
    endtask

    task automatic check_quiet(input string tag);
        check_output({tag, "_ctl"}, 36'({busy, done, err, ctrl_we, cur_layer, desc_addr, ctrl_addr}), 36'd0);
        check_output({tag, "_wdata"}, 36'(ctrl_wdata), 36'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        int t;
        int w;
        for (int i = 0; i < 256; i++) desc_mem[i] = $urandom;
        for (int i = 0; i < 16; i++) ctrl_mem[i] = 32'd0;
        #1;
        check_quiet("reset");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        mon_en = 1'b1;

        // Reset asserted mid-LOAD
        fill_layer(0, 3'd1);
        clear_mon();
        apply_stimulus(5'd1, t);
        tick(); tick(); tick();
        check_output("midload_busy", 36'(busy), 36'd1);
        rst_n = 1'b0;
        #1;
        check_quiet("midload_rst");
        tick();
        rst_n = 1'b1;
        clear_mon();
        for (int k = 0; k < 5; k++) tick();
        check_output("post_rst_writes", 36'(got_q.size()), 36'd0);

        // One layer, directed descriptor
        desc_mem[0] = 32'h0001_0808;
        desc_mem[1] = $urandom;
        for (int k = 2; k <= 10; k++) desc_mem[k] = 32'(k - 1);
        desc_mem[11] = 32'd1;
        dp_enable = 1'b1;
        dp_delay = 50;
        clear_mon();
        apply_stimulus(5'd1, t);
        w = -1;
        for (int k = 0; k < 400 && busy; k++) begin
            if (w < 0 && got_q.size() >= 12 && ctrl_rd[1]) w = cyc;
            tick();
        end
        wait_idle("one", 1);
        build_expected(1);
        compare_writes("one");
        if (got_q.size() >= 13) begin
            check_output("one_first_wr_cyc", 36'(got_cyc[0]), 36'(t + 2));
            check_output("one_start_cyc", 36'(got_cyc[11]), 36'(t + 13));
            check_output("one_start_word", got_q[11], {4'd0, 32'h0000_0005});
            check_output("one_clear_cyc", 36'(got_cyc[12]), 36'(w + 1));
        end
        check_output("one_done_cnt", 36'(done_cnt), 36'd1);
        check_output("one_done_cyc", 36'(done_cyc), 36'(w + 2));
        check_output("one_err", 36'(err), 36'd0);

        // Three layers, middle one skipped
        fill_layer(0, 3'd1);
        fill_layer(1, 3'd0);
        fill_layer(2, 3'd1);
        dp_delay = $urandom_range(5, 30);
        clear_mon();
        apply_stimulus(5'd3, t);
        wait_idle("three", 1000);
        build_expected(3);
        compare_writes("three");
        check_output("three_nlayers", 36'(lay_q.size()), 36'd3);
        for (int i = 0; i < lay_q.size() && i < 3; i++)
            check_output($sformatf("three_layer%0d", i), 36'(lay_q[i]), 36'(i));
        check_output("three_done_cnt", 36'(done_cnt), 36'd1);

        // Zero layers
        clear_mon();
        apply_stimulus(5'd0, t);
        check_output("zero_done_pulse", 36'({done, busy}), 36'b10);
        tick();
        check_output("zero_done_drop", 36'(done), 36'd0);
        tick();
        tick();
        check_output("zero_writes", 36'(got_q.size()), 36'd0);
        check_output("zero_done_cnt", 36'(done_cnt), 36'd1);

        // Twenty layers clamp to sixteen; later num_layers changes ignored
        for (int l = 0; l < 16; l++) fill_layer(l, 3'($urandom_range(0, 7)));
        dp_delay = $urandom_range(3, 40);
        clear_mon();
        apply_stimulus(5'd20, t);
        tick(); tick();
        num_layers = 5'd2;
        wait_idle("sixteen", 5000);
        build_expected(20);
        compare_writes("sixteen");
        check_output("sixteen_nlayers", 36'(lay_q.size()), 36'd16);
        check_output("sixteen_cur_layer", 36'(cur_layer), 36'd15);
        check_output("sixteen_done_cnt", 36'(done_cnt), 36'd1);

        // Watchdog timeout, then o_err cleared by next accepted run
        fill_layer(0, 3'b110);
        dp_enable = 1'b0;
        clear_mon();
        apply_stimulus(5'd1, t);
        wait_idle("tmo", 400);
        build_expected(1);
        compare_writes("tmo");
        if (got_q.size() >= 13) begin
            check_output("tmo_clear_cyc", 36'(got_cyc[12]), 36'(got_cyc[11] + (1 << TW)));
            check_output("tmo_done_cyc", 36'(done_cyc), 36'(got_cyc[11] + (1 << TW)));
        end
        check_output("tmo_done_cnt", 36'(done_cnt), 36'd1);
        check_output("tmo_err_set", 36'(err), 36'd1);
        clear_mon();
        apply_stimulus(5'd0, t);
        check_output("tmo_err_clear", 36'(err), 36'd0);
        tick();

        // Abort in the same cycle done is seen; run while busy ignored
        fill_layer(0, 3'd1);
        dp_enable = 1'b1;
        dp_delay = 20;
        clear_mon();
        apply_stimulus(5'd1, t);
        tick(); tick(); tick();
        num_layers = 5'd5;
        run = 1'b1;
        tick();
        run = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (got_q.size() >= 12 && ctrl_rd[1]) break;
            tick();
        end
        check_output("abort_done_seen", 36'(ctrl_rd[1]), 36'd1);
        abort = 1'b1;
        w = cyc;
        #1;
        check_output("abort_cycle_quiet", 36'({done, ctrl_we}), 36'd0);
        tick();
        abort = 1'b0;
        check_output("abort_wr", 36'({busy, ctrl_we, ctrl_addr}), 36'b1_1_0000);
        check_output("abort_wdata", 36'(ctrl_wdata), 36'd0);
        tick();
        check_output("abort_idle", 36'(busy), 36'd0);
        tick();
        tick();
        build_expected(1);
        compare_writes("abort");
        if (got_q.size() >= 13) check_output("abort_wr_cyc", 36'(got_cyc[12]), 36'(w + 1));
        check_output("abort_done_cnt", 36'(done_cnt), 36'd0);
        check_output("abort_err", 36'(err), 36'd0);
        check_output("abort_cur_layer", 36'(cur_layer), 36'd0);

        check_output("idle_writes", 36'(idle_we), 36'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
